inst_dump_tx: RTL
=================

INST_DUMP_TX -- requirements
Module: inst_dump_tx

Interface
REQ-001 SHALL have parameter CLK_HZ, default 100000000, system clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, UART bit rate; bit period DIV = CLK_HZ/BAUD cycles (integer division).
REQ-003 SHALL have port clk  input  1  system clock; all logic on its rising edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-low.
REQ-005 SHALL have port start  input  1  one-cycle request to begin a dump.
REQ-006 SHALL have port base_addr  input  14  first word address, sampled when start is accepted.
REQ-007 SHALL have port word_count  input  15  words to send, 0..16384, sampled when start is accepted.
REQ-008 SHALL have port rom_addr  output  14  word address to the program ROM read port.
REQ-009 SHALL have port rom_data  input  32  ROM read data, valid one cycle after rom_addr is presented.
REQ-010 SHALL have port tx  output  1  UART serial output, 8N1, idle high.
REQ-011 SHALL have port busy  output  1  high from the cycle after start is accepted until the dump ends.
REQ-012 SHALL have port done  output  1  one-cycle pulse when a dump completes.

Function
REQ-013 SHALL accept start only in IDLE; start while busy SHALL be ignored, with no effect on the dump in progress.
REQ-014 SHALL, when start is accepted with word_count=0, pulse done on the next cycle without asserting busy and with tx held high.
REQ-015 SHALL use FSM states IDLE, FETCH, WAIT, LOAD, SEND, DONE: IDLE->FETCH on start; FETCH drives rom_addr; WAIT covers ROM latency; LOAD captures rom_data; SEND transmits 4 bytes; SEND->FETCH if words remain, else ->DONE; DONE->IDLE after one cycle.
REQ-016 SHALL address word i at (base_addr + i) mod 2^14; a dump crossing 16383 SHALL wrap to 0.
REQ-017 SHALL send each word as 4 frames, little-endian: rom_data[7:0] first, rom_data[31:24] last.
REQ-018 SHALL form each frame as a start bit (0), 8 data bits LSB first, and a stop bit (1), each held exactly DIV cycles.
REQ-019 SHALL begin the next byte's start bit on the cycle after the previous stop bit ends, within a word.
REQ-020 SHALL insert at most 3 idle-high cycles between the last stop bit of one word and the start bit of the next.
REQ-021 SHALL assert done for exactly one cycle, on the cycle after the final stop bit ends, and SHALL deassert busy on that same cycle.
REQ-022 SHALL keep tx high whenever no frame is being sent.
REQ-023 SHALL hold rom_addr stable from FETCH through LOAD.
REQ-024 SHALL count remaining words in 15 bits, so that word_count=16384 sends all 16384 words exactly once.

Reset
REQ-025 SHALL, while rst=0 at a clock edge, force state IDLE, tx=1, busy=0, done=0, rom_addr=0, and clear all counters.
REQ-026 SHALL, when reset occurs mid-frame, drive tx high on the cycle after the reset edge and send no partial remainder after release.
REQ-027 SHALL ignore start in any cycle in which rst=0.

Structure
REQ-028 SHALL place the FSM state encoding and the UART frame constants (8 data bits, 10 bits per frame) in the shared project package.
REQ-029 SHALL instantiate one sub-module, uart_tx_byte, with ports clk, rst, send, data[7:0], tx, and ready; it handles baud timing and serialization.
REQ-030 SHALL compute DIV inside uart_tx_byte from the parameters, with a baud counter sized $clog2(DIV).

Verification (bench: CLK_HZ=1000000, BAUD=100000, so DIV=10)
REQ-031 SHALL cover: ROM[5]=0x12345678, start with base 5, count 1 -> bytes 78,56,34,12 on tx, 40 bit periods (400 cycles) with no gaps, then done for 1 cycle.
REQ-032 SHALL cover: base 16383, count 2, ROM[16383]=0xAABBCCDD, ROM[0]=0x01020304 -> rom_addr 16383 then 0; bytes DD,CC,BB,AA,04,03,02,01; inter-word gap of at most 3 cycles.
REQ-033 SHALL cover: count 0 -> done high on the cycle after start, busy stays 0, tx stays 1.
REQ-034 SHALL cover: start pulsed again 50 cycles into a 1-word dump -> only 4 bytes sent and exactly one done pulse.
REQ-035 SHALL cover: rst=0 for 1 cycle at cycle 150 of a dump -> tx=1, busy=0 the next cycle; no further frames; a new start then sends a full correct dump.
REQ-036 SHALL cover: every frame sampled mid-bit -> start bit 0, stop bit 1, each bit exactly 10 cycles.

Source files
------------

// File: rtl/inst_dump_tx_pkg.sv
// Shared definitions for the instruction-dump UART transmitter:
// dump FSM encoding, frame geometry and word/address widths.
package inst_dump_tx_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        WAIT,
        LOAD,
        SEND,
        DONE
    } state_t;

    localparam int DATA_BITS      = 8;
    localparam int FRAME_BITS     = 10;
    localparam int ADDR_W         = 14;
    localparam int COUNT_W        = 15;
    localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/inst_dump_tx_uart_tx_byte.sv
// 8N1 byte serializer. ready is also high in the final cycle of a stop bit,
// so a send accepted then starts the next frame with no idle gap.
module uart_tx_byte
    import inst_dump_tx_pkg::*;
#(
    parameter int CLK_HZ = 100000000,
    parameter int BAUD   = 115200
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 send,
    input  logic [DATA_BITS-1:0] data,
    output logic                 tx,
    output logic                 ready
);

    localparam int DIV   = CLK_HZ / BAUD;
    localparam int CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int IDX_W = $clog2(FRAME_BITS);
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(DIV - 1);
    localparam logic [IDX_W-1:0] BIT_LAST  = IDX_W'(FRAME_BITS - 1);

    logic                  active_reg;
    logic [CNT_W-1:0]      baud_reg;
    logic [IDX_W-1:0]      bit_reg;
    logic [FRAME_BITS-1:0] shift_reg;
    logic                  tx_reg;
    logic                  bit_tick;
    logic                  frame_end;

    assign bit_tick  = active_reg && (baud_reg == BAUD_LAST);
    assign frame_end = bit_tick && (bit_reg == BIT_LAST);
    assign ready     = !active_reg || frame_end;
    assign tx        = tx_reg;

    always_ff @(posedge clk) begin
        if (!rst) begin
            active_reg <= 1'b0;
            baud_reg   <= '0;
            bit_reg    <= '0;
            shift_reg  <= '1;
            tx_reg     <= 1'b1;
        end else if (send && ready) begin
            // Frame is {stop, data, start}; bit 0 goes out first.
            active_reg <= 1'b1;
            baud_reg   <= '0;
            bit_reg    <= '0;
            shift_reg  <= {1'b1, data, 1'b0};
            tx_reg     <= 1'b0;
        end else if (frame_end) begin
            active_reg <= 1'b0;
            baud_reg   <= '0;
            bit_reg    <= '0;
            tx_reg     <= 1'b1;
        end else if (bit_tick) begin
            baud_reg  <= '0;
            bit_reg   <= bit_reg + 1'b1;
            shift_reg <= {1'b1, shift_reg[FRAME_BITS-1:1]};
            tx_reg    <= shift_reg[1];
        end else if (active_reg) begin
            baud_reg <= baud_reg + 1'b1;
        end
    end

endmodule

// File: rtl/inst_dump_tx.sv
// Streams a range of program-ROM words out of a UART, four little-endian
// bytes per word. The next word is prefetched while the last byte is on the line.
module inst_dump_tx
    import inst_dump_tx_pkg::*;
#(
    parameter int CLK_HZ = 100000000,
    parameter int BAUD   = 115200
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [ADDR_W-1:0]  base_addr,
    input  logic [COUNT_W-1:0] word_count,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [31:0]        rom_data,
    output logic               tx,
    output logic               busy,
    output logic               done
);

    localparam logic [2:0] BYTE_LAST = 3'(BYTES_PER_WORD - 1);
    localparam logic [2:0] BYTE_ALL  = 3'(BYTES_PER_WORD);

    state_t             state_reg, state_next;
    logic [ADDR_W-1:0]  addr_reg, addr_next;
    logic [COUNT_W-1:0] remain_reg, remain_next;
    logic [31:0]        word_reg, word_next;
    logic [2:0]         byte_reg, byte_next;

    logic                 send;
    logic                 uart_ready;
    logic [DATA_BITS-1:0] byte_data;
    logic [DATA_BITS-1:0] word_bytes [BYTES_PER_WORD];

    generate
        for (genvar gi = 0; gi < BYTES_PER_WORD; gi++) begin : g_bytes
            assign word_bytes[gi] = word_reg[gi*DATA_BITS +: DATA_BITS];
        end
    endgenerate

    assign byte_data = word_bytes[byte_reg[1:0]];
    assign rom_addr  = addr_reg;
    assign busy      = (state_reg == FETCH) || (state_reg == WAIT) ||
                       (state_reg == LOAD)  || (state_reg == SEND);
    assign done      = (state_reg == DONE);

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg  <= IDLE;
            addr_reg   <= '0;
            remain_reg <= '0;
            word_reg   <= '0;
            byte_reg   <= '0;
        end else begin
            state_reg  <= state_next;
            addr_reg   <= addr_next;
            remain_reg <= remain_next;
            word_reg   <= word_next;
            byte_reg   <= byte_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        addr_next   = addr_reg;
        remain_next = remain_reg;
        word_next   = word_reg;
        byte_next   = byte_reg;
        send        = 1'b0;
        case (state_reg)
            IDLE: begin
                if (start) begin
                    addr_next   = base_addr;
                    remain_next = word_count;
                    byte_next   = '0;
                    state_next  = (word_count == '0) ? DONE : FETCH;
                end
            end
            FETCH: state_next = WAIT;
            WAIT:  state_next = LOAD;
            LOAD: begin
                word_next  = rom_data;
                byte_next  = '0;
                state_next = SEND;
            end
            SEND: begin
                if (uart_ready) begin
                    if (byte_reg != BYTE_ALL) begin
                        send      = 1'b1;
                        byte_next = byte_reg + 3'd1;
                        // Handing over the last byte: fetch the next word
                        // while it shifts out so words follow back to back.
                        if (byte_reg == BYTE_LAST) begin
                            remain_next = remain_reg - 15'd1;
                            if (remain_reg != 15'd1) begin
                                addr_next  = addr_reg + 14'd1;
                                state_next = FETCH;
                            end
                        end
                    end else begin
                        state_next = DONE;
                    end
                end
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    uart_tx_byte #(
        .CLK_HZ(CLK_HZ),
        .BAUD  (BAUD)
    ) u_uart (
        .clk  (clk),
        .rst  (rst),
        .send (send),
        .data (byte_data),
        .tx   (tx),
        .ready(uart_ready)
    );

endmodule
